// File: rtl/tick_run_ctrl_if.sv
// Control/status bundle for tick_run_ctrl.
//   i_run_stop : one-cycle pulse, toggles run/hold
//   i_clear    : one-cycle pulse, requests count clear
//   i_rate_sel : tick rate select (0 slowest .. 3)
//   o_tick     : one-cycle enable, high the cycle the count advances
//   o_clear    : one-cycle strobe, high the cycle the count becomes 0 via clear
//   o_running  : high while in RUN
//   o_count    : current count value
// master drives the requests (testbench / button logic), slave is the controller.
interface tick_run_ctrl_if #(
  parameter int unsigned CountW = 14
);
  logic              i_run_stop;
  logic              i_clear;
  logic [1:0]        i_rate_sel;
  logic              o_tick;
  logic              o_clear;
  logic              o_running;
  logic [CountW-1:0] o_count;

  modport master (
    output i_run_stop, i_clear, i_rate_sel,
    input  o_tick, o_clear, o_running, o_count
  );

  modport slave (
    input  i_run_stop, i_clear, i_rate_sel,
    output o_tick, o_clear, o_running, o_count
  );
endinterface

// File: rtl/tick_run_ctrl.sv
// Run/hold/clear controller and programmable tick scheduler.
// Turns run_stop/clear pulses into an IDLE/RUN/HOLD state machine, divides the
// clock down to one-cycle ticks at a selectable rate while running, and keeps a
// wrapping 0..MAX_COUNT count. All outputs are registered.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : tick_run_ctrl_if slave (requests in, tick/clear/running/count out)
module tick_run_ctrl #(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned RATE0_HZ  = 1,
  parameter int unsigned RATE1_HZ  = 10,
  parameter int unsigned RATE2_HZ  = 100,
  parameter int unsigned RATE3_HZ  = 1000,
  parameter int unsigned MAX_COUNT = 9999
) (
  input logic             clk,
  input logic             reset,
  tick_run_ctrl_if.slave  bus
);

  localparam int unsigned Div0   = CLK_HZ / RATE0_HZ;
  localparam int unsigned Div1   = CLK_HZ / RATE1_HZ;
  localparam int unsigned Div2   = CLK_HZ / RATE2_HZ;
  localparam int unsigned Div3   = CLK_HZ / RATE3_HZ;
  // Rate 0 is the slowest, so its divisor bounds the prescaler width.
  localparam int unsigned PreW   = (Div0 > 2) ? $clog2(Div0) : 1;
  localparam int unsigned CountW = $clog2(MAX_COUNT + 1);
  localparam logic [CountW-1:0] MaxCnt = CountW'(MAX_COUNT);

  typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

  state_e            state_q, state_d;
  logic [PreW-1:0]   pre_q, pre_d;
  logic [1:0]        rate_q;
  logic              tick_q, tick_d;
  logic              clear_q, clear_d;
  logic              running_q;
  logic [CountW-1:0] count_q, count_d;
  logic [PreW-1:0]   div_m1;
  logic              rate_chg;

  always_comb begin
    unique case (rate_q)
      2'd0: div_m1 = PreW'(Div0 - 1);
      2'd1: div_m1 = PreW'(Div1 - 1);
      2'd2: div_m1 = PreW'(Div2 - 1);
      2'd3: div_m1 = PreW'(Div3 - 1);
    endcase
  end

  assign rate_chg = (bus.i_rate_sel != rate_q);

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    tick_d  = 1'b0;
    clear_d = 1'b0;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        pre_d = '0;
        // Clear beats run_stop; the strobe still fires even though count is 0.
        if (bus.i_clear) begin
          clear_d = 1'b1;
          count_d = '0;
        end else if (bus.i_run_stop) begin
          state_d = StRun;
        end
      end
      StRun: begin
        // run_stop beats clear; clear alone is ignored while running.
        if (bus.i_run_stop) begin
          state_d = StHold;  // prescaler held, a pending match is suppressed
        end else if (!rate_chg) begin
          if (pre_q == div_m1) begin
            pre_d   = '0;
            tick_d  = 1'b1;
            count_d = (count_q == MaxCnt) ? '0 : count_q + CountW'(1);
          end else begin
            pre_d = pre_q + PreW'(1);
          end
        end
      end
      StHold: begin
        if (bus.i_clear) begin
          state_d = StIdle;
          pre_d   = '0;
          count_d = '0;
          clear_d = 1'b1;
        end else if (bus.i_run_stop) begin
          state_d = StRun;
        end
      end
      default: begin
        state_d = StIdle;
        pre_d   = '0;
        count_d = '0;
      end
    endcase
    // A rate change restarts the prescaler in every state.
    if (rate_chg) pre_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      pre_q     <= '0;
      rate_q    <= 2'd0;
      tick_q    <= 1'b0;
      clear_q   <= 1'b0;
      running_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      rate_q    <= bus.i_rate_sel;
      tick_q    <= tick_d;
      clear_q   <= clear_d;
      running_q <= (state_d == StRun);
      count_q   <= count_d;
    end
  end

  assign bus.o_tick    = tick_q;
  assign bus.o_clear   = clear_q;
  assign bus.o_running = running_q;
  assign bus.o_count   = count_q;

endmodule

// File: tb/tb_tick_run_ctrl.sv
// Directed bench for tick_run_ctrl with DIV = 100/10/5/2 and MAX_COUNT = 9.
module tb_tick_run_ctrl;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  int   n;
  int   seen;

  tick_run_ctrl_if #(.CountW(4)) bus ();

  tick_run_ctrl #(
    .CLK_HZ   (100),
    .RATE0_HZ (1),
    .RATE1_HZ (10),
    .RATE2_HZ (20),
    .RATE3_HZ (50),
    .MAX_COUNT(9)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Edges until o_tick is seen, bounded by limit.
  task automatic wait_tick(input int limit, output int cnt);
    cnt = 0;
    do begin
      cyc();
      cnt++;
    end while (bus.o_tick !== 1'b1 && cnt < limit);
  endtask

  // Run k cycles and return how many ticks appeared.
  task automatic idle_cycles(input int k, output int ticks);
    ticks = 0;
    for (int i = 0; i < k; i++) begin
      cyc();
      if (bus.o_tick === 1'b1) ticks++;
    end
  endtask

  task automatic pulse_run();
    bus.i_run_stop = 1'b1;
    cyc();
    bus.i_run_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.i_clear = 1'b1;
    cyc();
    bus.i_clear = 1'b0;
  endtask

  task automatic pulse_both();
    bus.i_run_stop = 1'b1;
    bus.i_clear    = 1'b1;
    cyc();
    bus.i_run_stop = 1'b0;
    bus.i_clear    = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus.i_run_stop = 1'b0;
    bus.i_clear    = 1'b0;
    bus.i_rate_sel = 2'd1;
    cyc();
    cyc();
    check_val("rst_running", 32'(bus.o_running), 0);
    check_val("rst_count",   32'(bus.o_count),   0);
    check_val("rst_tick",    32'(bus.o_tick),    0);
    check_val("rst_clear",   32'(bus.o_clear),   0);
    reset = 1'b0;
    cyc();

    // Basic run at DIV=10.
    pulse_run();
    check_val("run_running", 32'(bus.o_running), 1);
    check_val("run_tick0",   32'(bus.o_tick),    0);
    for (int k = 1; k <= 3; k++) begin
      wait_tick(15, n);
      check_val("run_spacing", 32'(n), 10);
      check_val("run_count",   32'(bus.o_count), 32'(k));
    end

    // Hold with prescaler at 4, resume needs 6 more edges.
    for (int i = 0; i < 4; i++) cyc();
    pulse_run();
    check_val("hold_running", 32'(bus.o_running), 0);
    idle_cycles(50, seen);
    check_val("hold_ticks", 32'(seen), 0);
    check_val("hold_count", 32'(bus.o_count), 3);
    pulse_run();
    check_val("resume_running", 32'(bus.o_running), 1);
    wait_tick(15, n);
    check_val("resume_spacing", 32'(n), 6);
    check_val("resume_count",   32'(bus.o_count), 4);

    // Clear while running is ignored.
    pulse_clear();
    check_val("runclr_clear",   32'(bus.o_clear),   0);
    check_val("runclr_running", 32'(bus.o_running), 1);
    wait_tick(15, n);
    check_val("runclr_spacing", 32'(n), 9);
    check_val("runclr_count",   32'(bus.o_count), 5);

    // Both in RUN: run_stop wins -> HOLD.
    pulse_both();
    check_val("bothrun_running", 32'(bus.o_running), 0);
    check_val("bothrun_clear",   32'(bus.o_clear),   0);
    check_val("bothrun_count",   32'(bus.o_count),   5);

    // Clear in HOLD.
    pulse_clear();
    check_val("holdclr_count",   32'(bus.o_count),   0);
    check_val("holdclr_clear",   32'(bus.o_clear),   1);
    check_val("holdclr_running", 32'(bus.o_running), 0);
    cyc();
    check_val("holdclr_strobe1", 32'(bus.o_clear), 0);

    // Both in HOLD: clear wins -> IDLE.
    pulse_run();
    pulse_run();
    check_val("rehold_running", 32'(bus.o_running), 0);
    pulse_both();
    check_val("bothhold_clear",   32'(bus.o_clear),   1);
    check_val("bothhold_running", 32'(bus.o_running), 0);
    idle_cycles(15, seen);
    check_val("bothhold_ticks",   32'(seen), 0);
    check_val("bothhold_run2",    32'(bus.o_running), 0);

    // Clear in IDLE still strobes.
    pulse_clear();
    check_val("idleclr_clear", 32'(bus.o_clear), 1);

    // Wrap at DIV=2.
    bus.i_rate_sel = 2'd3;
    cyc();
    pulse_run();
    for (int k = 0; k < 9; k++) wait_tick(4, n);
    check_val("wrap_pre_count", 32'(bus.o_count), 9);
    wait_tick(4, n);
    check_val("wrap_spacing", 32'(n), 2);
    check_val("wrap_count",   32'(bus.o_count), 0);
    check_val("wrap_tick",    32'(bus.o_tick),  1);
    check_val("wrap_clear",   32'(bus.o_clear), 0);

    // Rate change mid-run at prescaler 57 (DIV=100 -> 5).
    bus.i_rate_sel = 2'd0;
    cyc();
    idle_cycles(57, seen);
    check_val("rate0_ticks", 32'(seen), 0);
    bus.i_rate_sel = 2'd2;
    cyc();
    check_val("ratechg_tick",  32'(bus.o_tick),  0);
    check_val("ratechg_count", 32'(bus.o_count), 0);
    wait_tick(8, n);
    check_val("ratechg_spacing", 32'(n), 5);
    check_val("ratechg_count1",  32'(bus.o_count), 1);

    // Rate change exactly when prescaler hits DIV-1 suppresses the tick.
    for (int i = 0; i < 4; i++) cyc();
    bus.i_rate_sel = 2'd1;
    cyc();
    check_val("ratem1_tick",  32'(bus.o_tick),  0);
    check_val("ratem1_count", 32'(bus.o_count), 1);
    wait_tick(15, n);
    check_val("ratem1_spacing", 32'(n), 10);
    check_val("ratem1_count2",  32'(bus.o_count), 2);

    // RUN->HOLD at DIV-1: no tick, prescaler keeps DIV-1.
    for (int i = 0; i < 9; i++) cyc();
    pulse_run();
    check_val("holdm1_tick",    32'(bus.o_tick),    0);
    check_val("holdm1_running", 32'(bus.o_running), 0);
    check_val("holdm1_count",   32'(bus.o_count),   2);
    pulse_run();
    check_val("resm1_tick", 32'(bus.o_tick), 0);
    wait_tick(15, n);
    check_val("resm1_spacing", 32'(n), 1);
    check_val("resm1_count",   32'(bus.o_count), 3);

    // Reset mid-run at count 7.
    for (int k = 0; k < 4; k++) wait_tick(15, n);
    check_val("prerst_count", 32'(bus.o_count), 7);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_val("midrst_count",   32'(bus.o_count),   0);
    check_val("midrst_tick",    32'(bus.o_tick),    0);
    check_val("midrst_running", 32'(bus.o_running), 0);
    check_val("midrst_clear",   32'(bus.o_clear),   0);
    idle_cycles(30, seen);
    check_val("midrst_ticks", 32'(seen), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tick_run_ctrl.md
Name: tick_run_ctrl

Overview:
- Run/hold/clear controller and programmable tick scheduler for the counter datapath.
- Converts single-cycle button pulses into a three-state run FSM.
- Generates one-cycle enable ticks at a selectable rate, only while running.
- Keeps the displayed count value (0..MAX_COUNT, wrapping) and emits a clear strobe for downstream display/counter logic.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- RATE0_HZ, 1, tick rate selected when rate_sel=0.
- RATE1_HZ, 10, tick rate selected when rate_sel=1.
- RATE2_HZ, 100, tick rate selected when rate_sel=2.
- RATE3_HZ, 1000, tick rate selected when rate_sel=3.
- MAX_COUNT, 9999, last count value before wrap to 0.
- Constraints: CLK_HZ divisible by every RATEn_HZ; each divisor DIVn = CLK_HZ/RATEn_HZ ≥ 2; RATE0_HZ is the slowest rate.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_run_stop  in  1  one-cycle pulse that toggles run/hold.
- i_clear  in  1  one-cycle pulse that requests count clear.
- i_rate_sel  in  2  tick rate select, may change at any time.
- o_tick  out  1  one-cycle enable pulse, high the cycle the count advances.
- o_clear  out  1  one-cycle strobe, high the cycle the count becomes 0 via clear.
- o_running  out  1  high while in RUN.
- o_count  out  $clog2(MAX_COUNT+1)  current count value.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (sampled high at a rising edge): state=IDLE, prescaler=0, o_tick=0, o_clear=0, o_running=0, o_count=0, stored rate_sel=0. Reset overrides all inputs and applies mid-run.
- Prescaler width: $clog2(DIV0).
- Selected divisor: DIV = DIVn for the stored rate_sel.
- States: IDLE (count 0, stopped), RUN, HOLD (stopped, count and prescaler retained).
- Transitions:
  - IDLE + run_stop -> RUN.
  - RUN + run_stop -> HOLD.
  - HOLD + run_stop -> RUN.
  - HOLD + clear -> IDLE.
  - IDLE + clear -> IDLE, and o_clear still pulses.
  - RUN + clear -> ignored.
- Simultaneous run_stop and clear:
  - In IDLE or HOLD, clear wins: result is IDLE with an o_clear pulse, and run_stop is dropped.
  - In RUN, run_stop wins: result is HOLD, and clear is dropped.
- o_running is registered and equals (state==RUN). It rises on the edge that samples run_stop.
- Prescaler operation:
  - Increments only in RUN.
  - Holds its value in HOLD.
  - Is forced to 0 in IDLE and on clear.
- Tick generation: in RUN, when prescaler==DIV-1 at an edge:
  - prescaler becomes 0,
  - o_tick=1 for the following cycle,
  - o_count advances on the same edge, so o_tick and the new count are visible together.
- Tick spacing: the first tick after IDLE->RUN appears DIV cycles after o_running rises. Ticks then repeat every DIV cycles.
- Resume from HOLD: the prescaler continues from its held value. No tick is lost or duplicated across the hold.
- Count wrap: o_count == MAX_COUNT plus a tick gives o_count=0. o_tick still pulses; o_clear does not.
- Rate change: i_rate_sel is registered every cycle. When the new value differs from the stored value:
  - prescaler is forced to 0 on that edge, and no tick fires on that edge even if the prescaler had reached DIV-1,
  - counting restarts under the new DIV,
  - o_count is unaffected,
  - this applies in every state; in HOLD the prescaler is zeroed and the new rate takes effect on resume.
- o_tick in non-RUN states: never asserted in IDLE or HOLD, including on the edge that leaves RUN. A pending DIV-1 match on the RUN->HOLD edge is suppressed and the prescaler holds DIV-1.
- Clear strobe: o_clear is high exactly one cycle, on the cycle o_count reads 0 after an accepted clear.
- All outputs are registered. There is no combinational path from any input to any output.

Test Plan:
Bench parameters: CLK_HZ=100, RATE0..3 = 1, 10, 20, 50, giving DIV = 100, 10, 5, 2. MAX_COUNT=9.
- Reset, rate_sel=1, run_stop pulse:
  - o_running=1 next cycle.
  - o_tick pulses every 10 cycles, first at cycle 10 after o_running rose.
  - o_count = 1, 2, 3 …
- Wrap: with rate_sel=3 (DIV=2), run until count=9; next tick -> o_count=0, o_tick=1, o_clear=0.
- Hold/resume:
  - rate_sel=1, run, stop at 4 cycles after a tick: o_running=0, no ticks for 50 cycles, count frozen.
  - Resume: next tick exactly 6 cycles after o_running rises.
- Clear semantics:
  - Clear in RUN: ignored, count keeps rising.
  - Clear in HOLD: o_count=0 with a one-cycle o_clear; state IDLE, o_running=0.
  - Simultaneous run_stop+clear in HOLD: IDLE, o_clear=1.
  - Simultaneous run_stop+clear in RUN: HOLD, no o_clear.
- Rate change mid-run: running rate_sel=0, switch to 2 when prescaler=57 -> no tick that edge; next tick 5 cycles later; count unchanged by the switch.
- Reset mid-run at count=7: next cycle o_count=0, o_tick=0, o_running=0, o_clear=0; no ticks until a new run_stop pulse.
